// File: rtl/eim_mac_pe.sv
// -----------------------------------------------------------------------------
// eim_mac_pe -- systolic MAC processing element built around the EIM multiplier
//
// Purpose:
//   Registers an activation/weight pair and forwards it east/south, multiplies
//   the registered pair in an EIM core, pipelines the product and accumulates
//   it into an output-stationary accumulator. The result is drained through a
//   valid/ready handshake once the pipeline is empty.
//
// Build option:
//   MAC_SAT_EN  defined   -> accumulator clamps to all-ones on overflow
//               undefined -> accumulator wraps modulo 2^ACC_W
//   Both builds set the sticky o_ovf flag on a carry out of ACC_W.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_a_in / i_b_in          activation (west) / weight (north)
//   i_in_valid / o_in_ready  operand handshake
//   o_a_out / o_b_out        registered operands to east / south neighbours
//   o_fwd_valid              o_a_out/o_b_out valid (one cycle per accept)
//   i_acc_clr                synchronous accumulator/counter/ovf clear
//   i_drain                  request the result once the pipeline empties
//   o_acc_out / o_acc_valid  accumulated result, held until i_acc_ready
//   i_acc_ready              downstream consumes the result
//   o_mac_cnt                products accumulated since last clear (saturating)
//   o_ovf                    sticky overflow flag since last clear
// -----------------------------------------------------------------------------

// EIM multiplier core: combinational unsigned product of the two operands.
module eim #(
  parameter int DW = 8,
  parameter int WW = 8
) (
  input  logic [DW-1:0]    i_a,
  input  logic [WW-1:0]    i_b,
  output logic [DW+WW-1:0] o_r
);
  assign o_r = (DW+WW)'(i_a) * (DW+WW)'(i_b);
endmodule

module eim_mac_pe #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [DW-1:0]    i_a_in,
  input  logic [WW-1:0]    i_b_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [DW-1:0]    o_a_out,
  output logic [WW-1:0]    o_b_out,
  output logic             o_fwd_valid,
  input  logic             i_acc_clr,
  input  logic             i_drain,
  output logic [ACC_W-1:0] o_acc_out,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic [CNT_W-1:0] o_mac_cnt,
  output logic             o_ovf
);

  typedef enum logic [0:0] {S_ACC = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_live;        // low only until the first edge after reset
  logic               r_drain_pend;
  logic [DW-1:0]      r_a;
  logic [WW-1:0]      r_b;
  logic               r_fwd_valid;
  logic [DW+WW-1:0]   r_p;
  logic               r_p_valid;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_acc_valid;
  logic               w_accept;
  logic               w_done;
  logic [DW+WW-1:0]   w_r;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_add;
  logic               w_ovf_add;
  logic [CNT_W-1:0]   w_cnt_inc;

  eim #(.DW(DW), .WW(WW)) u_eim (
    .i_a (r_a),
    .i_b (r_b),
    .o_r (w_r)
  );

  assign w_accept = i_in_valid && w_in_ready;
  assign w_done   = w_acc_valid && i_acc_ready;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a drain request (registered or arriving now) waits until
  // no operand is being accepted and both pipeline stages are empty.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC: begin
        if ((r_drain_pend || i_drain) && !r_fwd_valid && !r_p_valid && !w_accept) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_DRAIN: begin
        if (i_acc_ready) begin
          w_state_nxt = S_ACC;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  // FSM outputs: operand acceptance and result-valid.
  always_comb begin
    w_in_ready  = 1'b0;
    w_acc_valid = 1'b0;
    case (r_state)
      S_ACC: begin
        w_in_ready  = r_live && !r_drain_pend;
        w_acc_valid = 1'b0;
      end
      S_DRAIN: begin
        w_in_ready  = 1'b0;
        w_acc_valid = 1'b1;
      end
      default: begin
        w_in_ready  = 1'b0;
        w_acc_valid = 1'b0;
      end
    endcase
  end

  // Post-reset enable and drain-request bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live       <= 1'b0;
      r_drain_pend <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_done) begin
        r_drain_pend <= 1'b0;
      end else if (r_state == S_ACC && i_drain) begin
        r_drain_pend <= 1'b1;
      end
    end
  end

  // Stage 1: capture operands; forwarded outputs hold when nothing is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a         <= {DW{1'b0}};
      r_b         <= {WW{1'b0}};
      r_fwd_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= i_a_in;
        r_b <= i_b_in;
      end
      r_fwd_valid <= w_accept;
    end
  end

  // Stage 2: register the EIM product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p       <= {(DW+WW){1'b0}};
      r_p_valid <= 1'b0;
    end else begin
      if (r_fwd_valid) begin
        r_p <= w_r;
      end
      r_p_valid <= r_fwd_valid;
    end
  end

  // Accumulate path: one extra bit captures the carry out of ACC_W.
  always_comb begin
    w_sum     = {1'b0, r_acc} + (ACC_W+1)'(r_p);
    w_ovf_add = r_ovf | w_sum[ACC_W];
`ifdef MAC_SAT_EN
    // Once clamped the accumulator stays at all-ones until cleared.
    if (w_sum[ACC_W] || r_ovf) begin
      w_acc_add = {ACC_W{1'b1}};
    end else begin
      w_acc_add = w_sum[ACC_W-1:0];
    end
`else
    w_acc_add = w_sum[ACC_W-1:0];
`endif
    if (r_cnt == {CNT_W{1'b1}}) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + CNT_W'(1'b1);
    end
  end

  // Stage 3: accumulator, counter and sticky overflow. A clear that coincides
  // with a product loads that product so the product is not lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= {ACC_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
      r_ovf <= 1'b0;
    end else begin
      if (w_done) begin
        r_acc <= {ACC_W{1'b0}};
        r_cnt <= {CNT_W{1'b0}};
        r_ovf <= 1'b0;
      end else if (r_state == S_ACC && i_acc_clr) begin
        if (r_p_valid) begin
          r_acc <= ACC_W'(r_p);
          r_cnt <= CNT_W'(1'b1);
        end else begin
          r_acc <= {ACC_W{1'b0}};
          r_cnt <= {CNT_W{1'b0}};
        end
        r_ovf <= 1'b0;
      end else if (r_p_valid) begin
        r_acc <= w_acc_add;
        r_cnt <= w_cnt_inc;
        r_ovf <= w_ovf_add;
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_a_out     = r_a;
  assign o_b_out     = r_b;
  assign o_fwd_valid = r_fwd_valid;
  assign o_acc_out   = r_acc;
  assign o_acc_valid = w_acc_valid;
  assign o_mac_cnt   = r_cnt;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_eim_mac_pe.sv
module tb_eim_mac_pe;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    a_in;
  logic [WW-1:0]    b_in;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    a_out;
  logic [WW-1:0]    b_out;
  logic             fwd_valid;
  logic             acc_clr;
  logic             drain;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic [CNT_W-1:0] mac_cnt;
  logic             ovf;

  always #5 clk = ~clk;

  eim_mac_pe #(.DW(DW), .WW(WW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_in      (a_in),
    .i_b_in      (b_in),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_a_out     (a_out),
    .o_b_out     (b_out),
    .o_fwd_valid (fwd_valid),
    .i_acc_clr   (acc_clr),
    .i_drain     (drain),
    .o_acc_out   (acc_out),
    .o_acc_valid (acc_valid),
    .i_acc_ready (acc_ready),
    .o_mac_cnt   (mac_cnt),
    .o_ovf       (ovf)
  );

  typedef struct {
    logic [DW-1:0]    a;
    logic [WW-1:0]    b;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } item_t;

  item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference accumulator state
  logic [ACC_W-1:0] m_acc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ovf;

  // monitor pipeline (product seen on fwd_valid is accumulated two cycles later)
  item_t d1, d2;
  bit    d1v = 1'b0;
  bit    d2v = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+WW-1:0] eim_model(input logic [DW-1:0] a, input logic [WW-1:0] b);
    return (DW+WW)'(int'(a) * int'(b));
  endfunction

  task automatic model_clear();
    m_acc = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [DW+WW-1:0] p, input bit load);
    longint s;
    longint lim;
    lim = longint'(1) << ACC_W;
    if (load) begin
      m_acc = ACC_W'(p);
      m_cnt = 1;
      m_ovf = 1'b0;
    end else begin
      s = longint'(m_acc) + longint'(p);
      if (s >= lim) m_ovf = 1'b1;
`ifdef MAC_SAT_EN
      m_acc = m_ovf ? ACC_W'(lim - 1) : ACC_W'(s);
`else
      m_acc = ACC_W'(s % lim);
`endif
      if (m_cnt != CNT_W'(15)) m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // drive one operand pair for one cycle and push its expected outcome
  task automatic send(input logic [DW-1:0] a, input logic [WW-1:0] b, input bit load);
    item_t it;
    check_eq("send_ready", in_ready, 1);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    model_step(eim_model(a, b), load);
    it.a = a; it.b = b; it.acc = m_acc; it.cnt = m_cnt; it.ovf = m_ovf;
    sb.push_back(it);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_clear();
  endtask

  // scoreboard monitor
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        d1v = 1'b0;
        d2v = 1'b0;
      end else begin
        if (d2v) begin
          check_eq("sb_acc", acc_out, d2.acc);
          check_eq("sb_cnt", mac_cnt, d2.cnt);
          check_eq("sb_ovf", ovf, d2.ovf);
        end
        d2 = d1;
        d2v = d1v;
        d1v = 1'b0;
        if (fwd_valid) begin
          if (sb.size() == 0) begin
            check_eq("fwd_unexpected", fwd_valid, 0);
          end else begin
            it = sb.pop_front();
            check_eq("sb_a_out", a_out, it.a);
            check_eq("sb_b_out", b_out, it.b);
            d1 = it;
            d1v = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] held;
    rst_n = 1'b0; a_in = '0; b_in = '0; in_valid = 1'b0;
    acc_clr = 1'b0; drain = 1'b0; acc_ready = 1'b0;
    model_clear();
    #2;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_fwd_valid", fwd_valid, 0);
    check_eq("rst_acc_out", acc_out, 0);
    check_eq("rst_acc_valid", acc_valid, 0);
    check_eq("rst_mac_cnt", mac_cnt, 0);
    idle(3);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ready", in_ready, 1);

    // 1: single product 3*5
    send(8'd3, 8'd5, 1'b0);
    check_eq("t1_fwd_valid", fwd_valid, 1);
    check_eq("t1_a_out", a_out, 3);
    check_eq("t1_b_out", b_out, 5);
    idle(2);
    check_eq("t1_acc", acc_out, 15);
    check_eq("t1_cnt", mac_cnt, 1);
    idle(2);

    // 2: four (10,10) products, drain raised with the last operand
    clear_pulse();
    send(8'd10, 8'd10, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    drain = 1'b1;
    send(8'd10, 8'd10, 1'b0);
    drain = 1'b0;
    check_eq("t2_ready_drop", in_ready, 0);
    for (int k = 0; k < 20 && !acc_valid; k++) tick();
    check_eq("t2_drain_wait", acc_valid, 1);
    check_eq("t2_drain_sum", acc_out, 4 * eim_model(8'd10, 8'd10));
    check_eq("t2_drain_cnt", mac_cnt, 4);
    held = acc_out;

    // 5: hold acc_ready low in DRAIN while toggling operands
    for (int i = 0; i < 10; i++) begin
      a_in = DW'($urandom);
      in_valid = i[0];
      tick();
      check_eq("t5_acc_stable", acc_out, held);
      check_eq("t5_in_ready", in_ready, 0);
      check_eq("t5_fwd_valid", fwd_valid, 0);
      check_eq("t5_cnt", mac_cnt, 4);
      check_eq("t5_acc_valid", acc_valid, 1);
    end
    in_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    model_clear();
    check_eq("t2_hs_valid", acc_valid, 0);
    check_eq("t2_hs_acc", acc_out, 0);
    check_eq("t2_hs_cnt", mac_cnt, 0);
    check_eq("t2_hs_ready", in_ready, 1);

    // drain with an empty pipeline enters DRAIN on the next cycle
    drain = 1'b1;
    tick();
    drain = 1'b0;
    check_eq("empty_drain_valid", acc_valid, 1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check_eq("empty_drain_done", acc_valid, 0);

    // 3: acc_clr coincident with a product (4*5=20) loads it
    send(8'd2, 8'd2, 1'b0);
    idle(3);
    send(8'd4, 8'd5, 1'b1);
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check_eq("t3_acc", acc_out, 20);
    check_eq("t3_cnt", mac_cnt, 1);
    check_eq("t3_ovf", ovf, 0);
    idle(2);

    // 4: overflow with 255*255 twice, then counter saturation
    clear_pulse();
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b0);
    idle(3);
`ifdef MAC_SAT_EN
    check_eq("t4_acc", acc_out, 16'hFFFF);
`else
    check_eq("t4_acc", acc_out, 16'd64514);
`endif
    check_eq("t4_ovf", ovf, 1);
    for (int i = 0; i < 16; i++) send(8'd1, 8'd1, 1'b0);
    idle(3);
`ifdef MAC_SAT_EN
    check_eq("t4_acc_hold", acc_out, 16'hFFFF);
`else
    check_eq("t4_acc_wrap", acc_out, 16'd64530);
`endif
    check_eq("t4_cnt_sat", mac_cnt, 4'hF);
    check_eq("t4_ovf_sticky", ovf, 1);

    // 6: asynchronous reset while a product is in stage 2
    clear_pulse();
    send(8'd9, 8'd9, 1'b0);
    send(8'd8, 8'd8, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_clear();
    check_eq("t6_fwd_valid", fwd_valid, 0);
    check_eq("t6_a_out", a_out, 0);
    check_eq("t6_acc", acc_out, 0);
    check_eq("t6_cnt", mac_cnt, 0);
    check_eq("t6_ovf", ovf, 0);
    check_eq("t6_in_ready", in_ready, 0);
    idle(2);
    rst_n = 1'b1;
    tick();
    send(8'd6, 8'd7, 1'b0);
    idle(3);
    check_eq("t6_first_acc", acc_out, 42);
    check_eq("t6_first_cnt", mac_cnt, 1);

    idle(2);
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
